// File: rtl/arb_2to1_rr_if.sv
// Handshake bundle for arb_2to1_rr: two valid/ready sources in, one registered stream out.
// The arbiter connects through the slave modport and its driver through the master modport.
interface arb_2to1_rr_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] i0_data;
  logic              i0_valid;
  logic              i0_last;
  logic              i0_ready;
  logic [DATA_W-1:0] i1_data;
  logic              i1_valid;
  logic              i1_last;
  logic              i1_ready;
  logic              select_n;
  logic [DATA_W-1:0] y_data;
  logic              y_valid;
  logic              y_last;
  logic              y_ready;

  modport slave (
    input  i0_data, i0_valid, i0_last,
    input  i1_data, i1_valid, i1_last,
    input  y_ready,
    output i0_ready, i1_ready,
    output select_n, y_data, y_valid, y_last
  );

  modport master (
    output i0_data, i0_valid, i0_last,
    output i1_data, i1_valid, i1_last,
    output y_ready,
    input  i0_ready, i1_ready,
    input  select_n, y_data, y_valid, y_last
  );
endinterface

// File: rtl/arb_2to1_rr.sv
// Two-input round-robin stream arbiter with a single registered output slice (1-cycle latency).
// Optional packet locking on the last marker is built when ARB_LAST_LOCK_EN is defined.
module arb_2to1_rr #(
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  arb_2to1_rr_if.slave bus
);

  logic [DATA_W-1:0] y_data_q, y_data_d;
  logic              y_valid_q, y_valid_d;
  logic              y_last_q, y_last_d;
  logic              sel_q, sel_d;
  logic              prio_q, prio_d;

  logic              load_en;
  logic              elig0, elig1;
  logic              grant_vld;
  logic              grant_sel;
  logic              xfer;
  logic              xfer_last;
  logic [DATA_W-1:0] xfer_data;

`ifdef ARB_LAST_LOCK_EN
  logic              lock_q, lock_d;
  logic              owner_q, owner_d;
`endif

  // The output register can take a new beat when it is empty or being drained this cycle.
  assign load_en = ~y_valid_q | bus.y_ready;

`ifdef ARB_LAST_LOCK_EN
  // While a packet is open only its owner is eligible, even when the owner is idle.
  assign elig0 = bus.i0_valid & ~(lock_q & owner_q);
  assign elig1 = bus.i1_valid & ~(lock_q & ~owner_q);
`else
  assign elig0 = bus.i0_valid;
  assign elig1 = bus.i1_valid;
`endif

  assign grant_vld = elig0 | elig1;
  assign grant_sel = (elig0 & elig1) ? prio_q : elig1;
  assign xfer      = rst_n & load_en & grant_vld;
  assign xfer_last = grant_sel ? bus.i1_last : bus.i0_last;
  assign xfer_data = grant_sel ? bus.i1_data : bus.i0_data;

  assign bus.i0_ready = xfer & ~grant_sel;
  assign bus.i1_ready = xfer & grant_sel;

  always_comb begin
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    sel_d     = sel_q;
    prio_d    = prio_q;
`ifdef ARB_LAST_LOCK_EN
    lock_d    = lock_q;
    owner_d   = owner_q;
`endif
    if (xfer) begin
      y_data_d  = xfer_data;
      y_last_d  = xfer_last;
      sel_d     = grant_sel;
      y_valid_d = 1'b1;
`ifdef ARB_LAST_LOCK_EN
      lock_d    = ~xfer_last;
      owner_d   = grant_sel;
      if (xfer_last) begin
        prio_d = ~grant_sel;
      end
`else
      prio_d    = ~grant_sel;
`endif
    end else if (load_en) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
      sel_q     <= 1'b0;
      prio_q    <= 1'b0;
`ifdef ARB_LAST_LOCK_EN
      lock_q    <= 1'b0;
      owner_q   <= 1'b0;
`endif
    end else begin
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
      sel_q     <= sel_d;
      prio_q    <= prio_d;
`ifdef ARB_LAST_LOCK_EN
      lock_q    <= lock_d;
      owner_q   <= owner_d;
`endif
    end
  end

  assign bus.y_data   = y_data_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.y_last   = y_last_q;
  assign bus.select_n = sel_q;

endmodule
